// File: rtl/swg_runtime_loop_controller.sv
// swg_runtime_loop_controller: runtime-configured H/W/KH/KW/SIMD loop sequencer with a shadow config slot
module swg_runtime_loop_controller #(
  parameter int INCR_BITWIDTH = 8,
  parameter int CNT_BITWIDTH  = 16
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic [5*CNT_BITWIDTH-1:0]    cfg_counts,
  input  logic [5*INCR_BITWIDTH-1:0]   cfg_head_incr,
  input  logic [3*INCR_BITWIDTH-1:0]   cfg_tail_incr,
  input  logic                         advance,
  output logic                         cmd_valid,
  output logic [INCR_BITWIDTH-1:0]     addr_incr,
  output logic [INCR_BITWIDTH-1:0]     tail_incr,
  output logic                         last_step,
  output logic                         fm_done
);
  localparam int IW = INCR_BITWIDTH;
  localparam int CW = CNT_BITWIDTH;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  localparam logic [2:0] LAST = 3'd5;
  typedef struct packed {
    logic [4:0][CW-1:0] cnt;
    logic [4:0][IW-1:0] head;
    logic [2:0][IW-1:0] tail;
  } cfg_t;
  cfg_t cfg_in, act_q, act_d, sh_q, sh_d;
  logic [4:0][CW-1:0] c_q, c_d;
  logic [0:0] state_q, state_d;
  logic sh_v_q, sh_v_d, hs, fm_done_d, last_d;
  logic [IW-1:0] addr_d, tail_d;
  logic [2:0] lvl_q, lvl_d;
  // innermost loop level whose down-counter is still nonzero, LAST when the FM is on its final fetch
  function automatic logic [2:0] level(input logic [4:0][CW-1:0] c);
    level = LAST;
    for (int i = 4; i >= 0; i--) if (c[i] != '0) level = 3'(i);
  endfunction
  assign cfg_in    = {cfg_counts, cfg_head_incr, cfg_tail_incr};
  assign cfg_ready = ap_rst_n && !sh_v_q;
  assign hs        = cfg_valid && cfg_ready;
  assign cmd_valid = (state_q == RUN);
  assign lvl_q     = level(c_q);
  assign lvl_d     = level(c_d);
  // next config/counter state; outputs are precomputed from it so they track c with no extra lag
  always_comb begin
    act_d     = act_q;
    sh_d      = sh_q;
    sh_v_d    = sh_v_q;
    c_d       = c_q;
    state_d   = state_q;
    fm_done_d = 1'b0;
    if (state_q == IDLE) begin
      if (hs) begin
        act_d   = cfg_in;
        c_d     = cfg_in.cnt;
        state_d = RUN;
      end
    end else if (advance && lvl_q != LAST) begin
      for (int i = 0; i < 5; i++)
        if (3'(i) < lvl_q) c_d[i] = act_q.cnt[i];
        else if (3'(i) == lvl_q) c_d[i] = c_q[i] - CW'(1);
      if (hs) begin
        sh_d   = cfg_in;
        sh_v_d = 1'b1;
      end
    end else if (advance) begin
      fm_done_d = 1'b1;
      if (sh_v_q) begin
        act_d  = sh_q;
        c_d    = sh_q.cnt;
        sh_v_d = 1'b0;
      end else if (hs) begin
        act_d = cfg_in;
        c_d   = cfg_in.cnt;
      end else c_d = act_q.cnt;
    end else if (hs) begin
      sh_d   = cfg_in;
      sh_v_d = 1'b1;
    end
    addr_d = (state_d != RUN || lvl_d == LAST) ? '0 : act_d.head[lvl_d];
    tail_d = (state_d != RUN) ? '0 :
             (lvl_d == LAST) ? act_d.tail[2] :
             (lvl_d == 3'd4) ? act_d.tail[1] :
             (lvl_d == 3'd3) ? act_d.tail[0] : IW'(1);
    last_d = (state_d == RUN) && (lvl_d == LAST);
  end
  // state and output registers, cleared asynchronously
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q   <= IDLE;
      act_q     <= '0;
      sh_q      <= '0;
      sh_v_q    <= 1'b0;
      c_q       <= '0;
      addr_incr <= '0;
      tail_incr <= '0;
      last_step <= 1'b0;
      fm_done   <= 1'b0;
    end else begin
      state_q   <= state_d;
      act_q     <= act_d;
      sh_q      <= sh_d;
      sh_v_q    <= sh_v_d;
      c_q       <= c_d;
      addr_incr <= addr_d;
      tail_incr <= tail_d;
      last_step <= last_d;
      fm_done   <= fm_done_d;
    end
  end
endmodule

// File: tb/tb_swg_runtime_loop_controller.sv
// tb_swg_runtime_loop_controller: directed vector table plus randomized run against a mixed-radix reference model
module tb_swg_runtime_loop_controller;
  typedef struct packed {
    logic [4:0][15:0] cnt;
    logic [4:0][7:0]  head;
    logic [2:0][7:0]  tail;
  } cfg_t;
  typedef struct packed {
    logic [1:0] sel;
    logic       v, a;
    logic [7:0] ea, et;
    logic       el, ed, er;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0, cfg_valid = 1'b0, advance = 1'b0;
  logic cfg_ready, cmd_valid, last_step, fm_done;
  logic [7:0] addr_incr, tail_incr;
  cfg_t cur, ca, cb, cc;
  vec_t tv [23];
  int checks = 0, failures = 0;
  logic m_act, m_sh, m_done, hs;
  cfg_t m_a, m_s;
  int m_idx;
  logic [7:0] ea, et;
  logic el;

  always #5 clk = ~clk;

  swg_runtime_loop_controller #(.INCR_BITWIDTH(8), .CNT_BITWIDTH(16)) dut (
    .ap_clk(clk), .ap_rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_counts(cur.cnt), .cfg_head_incr(cur.head), .cfg_tail_incr(cur.tail),
    .advance(advance), .cmd_valid(cmd_valid), .addr_incr(addr_incr), .tail_incr(tail_incr),
    .last_step(last_step), .fm_done(fm_done)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int total(input cfg_t c);
    int t = 1;
    for (int i = 0; i < 5; i++) t *= int'(c.cnt[i]) + 1;
    return t;
  endfunction

  // fetch n of an FM is the mixed-radix step n->n+1; its level is the lowest digit not at its maximum
  task automatic model_out(output logic [7:0] a, output logic [7:0] t, output logic l);
    int n, d, lv;
    bit found;
    if (m_idx == total(m_a) - 1) begin
      a = 8'd0; t = m_a.tail[2]; l = 1'b1;
    end else begin
      n = m_idx; lv = 0; found = 0;
      for (int i = 0; i < 5; i++) begin
        d = n % (int'(m_a.cnt[i]) + 1);
        n = n / (int'(m_a.cnt[i]) + 1);
        if (!found && d != int'(m_a.cnt[i])) begin lv = i; found = 1; end
      end
      a = m_a.head[lv];
      t = (lv == 3) ? m_a.tail[0] : (lv == 4) ? m_a.tail[1] : 8'd1;
      l = 1'b0;
    end
  endtask

  function automatic cfg_t rnd_cfg();
    cfg_t c;
    for (int i = 0; i < 5; i++) begin
      c.cnt[i]  = 16'($urandom_range(0, i < 3 ? 2 : 1));
      c.head[i] = 8'($urandom);
    end
    for (int i = 0; i < 3; i++) c.tail[i] = 8'($urandom);
    return c;
  endfunction

  initial begin
    ca = '{cnt: {16'd0, 16'd0, 16'd0, 16'd1, 16'd1}, head: {8'd0, 8'd0, 8'd5, 8'hFF, 8'd1}, tail: {8'd7, 8'd3, 8'd2}};
    cb = '{cnt: {16'd0, 16'd0, 16'd0, 16'd1, 16'd0}, head: {8'd0, 8'd0, 8'd0, 8'd4, 8'd3}, tail: {8'd11, 8'd10, 8'd9}};
    cc = '{cnt: '0, head: {8'd0, 8'd0, 8'd0, 8'd0, 8'd5}, tail: {8'd13, 8'd0, 8'd0}};
    //         sel   v     a     addr    tail    last  done  ready
    tv[0]  = '{2'd0, 1'b1, 1'b0, 8'd1,   8'd1,   1'b0, 1'b0, 1'b1};
    tv[1]  = '{2'd0, 1'b0, 1'b1, 8'hFF,  8'd1,   1'b0, 1'b0, 1'b1};
    tv[2]  = '{2'd0, 1'b0, 1'b1, 8'd1,   8'd1,   1'b0, 1'b0, 1'b1};
    tv[3]  = '{2'd0, 1'b0, 1'b1, 8'd0,   8'd7,   1'b1, 1'b0, 1'b1};
    tv[4]  = '{2'd0, 1'b0, 1'b1, 8'd1,   8'd1,   1'b0, 1'b1, 1'b1};
    tv[5]  = '{2'd0, 1'b0, 1'b1, 8'hFF,  8'd1,   1'b0, 1'b0, 1'b1};
    tv[6]  = '{2'd0, 1'b0, 1'b1, 8'd1,   8'd1,   1'b0, 1'b0, 1'b1};
    tv[7]  = '{2'd0, 1'b0, 1'b1, 8'd0,   8'd7,   1'b1, 1'b0, 1'b1};
    tv[8]  = '{2'd0, 1'b0, 1'b1, 8'd1,   8'd1,   1'b0, 1'b1, 1'b1};
    tv[9]  = '{2'd0, 1'b0, 1'b1, 8'hFF,  8'd1,   1'b0, 1'b0, 1'b1};
    tv[10] = '{2'd0, 1'b0, 1'b1, 8'd1,   8'd1,   1'b0, 1'b0, 1'b1};
    tv[11] = '{2'd0, 1'b0, 1'b1, 8'd0,   8'd7,   1'b1, 1'b0, 1'b1};
    tv[12] = '{2'd0, 1'b0, 1'b1, 8'd1,   8'd1,   1'b0, 1'b1, 1'b1};
    tv[13] = '{2'd1, 1'b1, 1'b1, 8'hFF,  8'd1,   1'b0, 1'b0, 1'b0};
    tv[14] = '{2'd1, 1'b0, 1'b1, 8'd1,   8'd1,   1'b0, 1'b0, 1'b0};
    tv[15] = '{2'd1, 1'b0, 1'b1, 8'd0,   8'd7,   1'b1, 1'b0, 1'b0};
    tv[16] = '{2'd1, 1'b0, 1'b1, 8'd4,   8'd1,   1'b0, 1'b1, 1'b1};
    tv[17] = '{2'd1, 1'b0, 1'b0, 8'd4,   8'd1,   1'b0, 1'b0, 1'b1};
    tv[18] = '{2'd1, 1'b0, 1'b1, 8'd0,   8'd11,  1'b1, 1'b0, 1'b1};
    tv[19] = '{2'd2, 1'b1, 1'b1, 8'd0,   8'd13,  1'b1, 1'b1, 1'b1};
    tv[20] = '{2'd2, 1'b0, 1'b1, 8'd0,   8'd13,  1'b1, 1'b1, 1'b1};
    tv[21] = '{2'd2, 1'b0, 1'b1, 8'd0,   8'd13,  1'b1, 1'b1, 1'b1};
    tv[22] = '{2'd2, 1'b0, 1'b0, 8'd0,   8'd13,  1'b1, 1'b0, 1'b1};
    cur = ca;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd", 16'(cmd_valid), 16'd0);
    chk("rst_addr", 16'(addr_incr), 16'd0);
    chk("rst_tail", 16'(tail_incr), 16'd0);
    chk("rst_last", 16'(last_step), 16'd0);
    chk("rst_done", 16'(fm_done), 16'd0);
    chk("rst_ready", 16'(cfg_ready), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("idle_ready", 16'(cfg_ready), 16'd1);
    for (int i = 0; i < 23; i++) begin
      cur = (tv[i].sel == 2'd0) ? ca : (tv[i].sel == 2'd1) ? cb : cc;
      cfg_valid = tv[i].v;
      advance   = tv[i].a;
      @(posedge clk);
      #1;
      cfg_valid = 1'b0;
      chk($sformatf("v%0d_cmd", i), 16'(cmd_valid), 16'd1);
      chk($sformatf("v%0d_addr", i), 16'(addr_incr), 16'(tv[i].ea));
      chk($sformatf("v%0d_tail", i), 16'(tail_incr), 16'(tv[i].et));
      chk($sformatf("v%0d_last", i), 16'(last_step), 16'(tv[i].el));
      chk($sformatf("v%0d_done", i), 16'(fm_done), 16'(tv[i].ed));
      chk($sformatf("v%0d_ready", i), 16'(cfg_ready), 16'(tv[i].er));
    end
    advance = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_cmd", 16'(cmd_valid), 16'd0);
    chk("arst_addr", 16'(addr_incr), 16'd0);
    chk("arst_tail", 16'(tail_incr), 16'd0);
    chk("arst_last", 16'(last_step), 16'd0);
    chk("arst_done", 16'(fm_done), 16'd0);
    chk("arst_ready", 16'(cfg_ready), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_cmd", 16'(cmd_valid), 16'd0);
      chk("post_rst_tail", 16'(tail_incr), 16'd0);
      chk("post_rst_last", 16'(last_step), 16'd0);
      chk("post_rst_done", 16'(fm_done), 16'd0);
    end
    m_act = 1'b0; m_sh = 1'b0; m_done = 1'b0; m_idx = 0; m_a = '0; m_s = '0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      model_out(ea, et, el);
      chk("rnd_cmd", 16'(cmd_valid), 16'(m_act));
      chk("rnd_addr", 16'(addr_incr), m_act ? 16'(ea) : 16'd0);
      chk("rnd_tail", 16'(tail_incr), m_act ? 16'(et) : 16'd0);
      chk("rnd_last", 16'(last_step), m_act ? 16'(el) : 16'd0);
      chk("rnd_done", 16'(fm_done), 16'(m_done));
      chk("rnd_ready", 16'(cfg_ready), 16'(!m_sh));
      advance   = ($urandom_range(0, 9) < 7);
      cfg_valid = ($urandom_range(0, 7) == 0);
      cur       = rnd_cfg();
      hs        = cfg_valid && !m_sh;
      m_done    = 1'b0;
      if (!m_act) begin
        if (hs) begin m_a = cur; m_act = 1'b1; m_idx = 0; end
      end else if (advance) begin
        if (m_idx < total(m_a) - 1) begin
          m_idx++;
          if (hs) begin m_s = cur; m_sh = 1'b1; end
        end else begin
          m_done = 1'b1;
          m_idx  = 0;
          if (m_sh) begin m_a = m_s; m_sh = 1'b0; end
          else if (hs) m_a = cur;
        end
      end else if (hs) begin
        m_s = cur; m_sh = 1'b1;
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
